// File: rtl/adc_sample_scheduler_pkg.sv
// Shared types and constants for the ADC sample scheduler and its output FIFO.
package adc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_TRIGGER,
    S_COLLECT
  } state_t;

  localparam int unsigned MIN_PERIOD = 16;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  ch;
    logic [15:0] frame;
  } fifo_word_t;

  function automatic int unsigned clamp_period(input int unsigned p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

endpackage

// File: rtl/adc_sample_scheduler_if.sv
// ADC driver handshake plus downstream sample stream, seen from the scheduler (master).
interface adc_sample_scheduler_if;
  logic        conv_start;
  logic        ch_valid;
  logic [15:0] ch_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_ch;
  logic [15:0] out_frame;

  modport master (
    output conv_start, out_valid, out_data, out_ch, out_frame,
    input  ch_valid, ch_data, out_ready
  );

  modport slave (
    input  conv_start, out_valid, out_data, out_ch, out_frame,
    output ch_valid, ch_data, out_ready
  );
endinterface

// File: rtl/adc_sample_scheduler_fifo.sv
// Synchronous sample FIFO; head word is read combinationally so a push is visible next cycle.
module sample_fifo
  import adc_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  fifo_word_t                 i_wdata,
  input  logic                       i_pop,
  output fifo_word_t                 o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_free
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_word_t    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_free  = CW'(DEPTH) - r_count;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Periodic ADC frame scheduler: triggers conversions, tags channel words, buffers them downstream.
//   state     | meaning
//   S_IDLE    | sampling disabled, waiting for enable
//   S_ARMED   | period counter running, waiting for tick
//   S_TRIGGER | single cycle with conv_start high
//   S_COLLECT | capturing NUM_CH channel words from the driver
module adc_sample_scheduler
  import adc_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int PERIOD_W   = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  adc_sample_scheduler_if.master bus,
  output logic                overrun,
  output logic [15:0]         drop_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_per_cnt;
  logic [2:0]          r_ch_idx;
  logic [15:0]         r_frame_cnt;
  logic                r_conv_start;
  logic                r_overrun;
  logic [15:0]         r_drop_cnt;

  logic                w_tick;
  logic                w_can_start;
  logic                w_drop;
  logic                w_take;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_last;
  logic [CW-1:0]       w_free;
  logic [PERIOD_W-1:0] w_reload;
  fifo_word_t          w_wdata;
  fifo_word_t          w_rdata;

  assign w_reload    = PERIOD_W'(clamp_period(32'(period)) - 32'd1);
  assign w_tick      = (r_state != S_IDLE) && (r_per_cnt == '0);
  assign w_can_start = (w_free >= CW'(NUM_CH));
  assign w_take      = (r_state == S_COLLECT) && bus.ch_valid;
  assign w_pop       = ~w_empty & bus.out_ready;
  assign w_push      = w_take & (~w_full | w_pop);
  assign w_last      = (r_ch_idx == 3'(NUM_CH - 1));
  assign w_wdata     = '{data: bus.ch_data, ch: r_ch_idx, frame: r_frame_cnt};

  // A tick is lost when the FIFO cannot hold a whole frame or a frame is still in flight.
  assign w_drop = w_tick && (((r_state == S_ARMED) && enable && !w_can_start) ||
                             (r_state == S_TRIGGER) || (r_state == S_COLLECT));

  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_free  (w_free)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_per_cnt    <= '0;
      r_ch_idx     <= '0;
      r_frame_cnt  <= '0;
      r_conv_start <= 1'b0;
      r_overrun    <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_conv_start <= 1'b0;
      if (r_state != S_IDLE) r_per_cnt <= w_tick ? w_reload : r_per_cnt - PERIOD_W'(1);
      if (w_drop) begin
        r_overrun <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_per_cnt <= w_reload;
            r_state   <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (w_tick && w_can_start) begin
            r_state      <= S_TRIGGER;
            r_conv_start <= 1'b1;
          end
        end
        S_TRIGGER: r_state <= S_COLLECT;
        S_COLLECT: begin
          if (w_take) begin
            if (w_last) begin
              r_ch_idx    <= '0;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_state     <= enable ? S_ARMED : S_IDLE;
            end else begin
              r_ch_idx <= r_ch_idx + 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.conv_start = r_conv_start;
  assign bus.out_valid  = ~w_empty;
  assign bus.out_data   = w_rdata.data;
  assign bus.out_ch     = w_rdata.ch;
  assign bus.out_frame  = w_rdata.frame;
  assign overrun        = r_overrun;
  assign drop_cnt       = r_drop_cnt;

endmodule
